multdiv_x_unit: RTL and testbench



---
 rtl/multdiv_x_unit.sv | 172 +++++++++++++++++
 tb/tb_multdiv_x_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/multdiv_x_unit.sv
// multdiv_x_unit: iterative signed multiply / divide for the execute stage.
// Multiply is a sign-magnitude shift-add over WIDTH edges, and divide is a
// restoring divide over WIDTH edges. While the unit is busy it stalls the
// front of the pipe. The result is presented for one cycle in DONE.
module multdiv_x_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             is_mult,
    input  logic             is_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [TAG_W-1:0] rd_in,
    output logic             stall,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_rdy,
    output logic [TAG_W-1:0] rd_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;        // |multiplicand|, or dividend shifting into quotient
    logic [WIDTH-1:0]   b_q, b_d;        // |divisor|
    logic [2*WIDTH-1:0] acc_q, acc_d;    // mul: {partial hi, multiplier}; div: remainder in low half
    logic               neg_q, neg_d;    // operand signs differ
    logic               dz_q, dz_d;      // divisor was zero at start
    logic               ovf_q, ovf_d;    // most-negative / -1 divide
    logic [TAG_W-1:0]   rd_q, rd_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               exc_q, exc_d;
    logic [TAG_W-1:0]   rdo_q, rdo_d;

    logic               start, last;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_next, prod;
    logic [WIDTH:0]     trial;
    logic               ge;
    logic [WIDTH-1:0]   quo_next, quo;

    assign start = is_mult | is_div;
    assign last  = (cnt_q == CNT_W'(WIDTH - 1));
    assign abs_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign abs_b = operand_b[WIDTH-1] ? -operand_b : operand_b;

    // State and datapath registers; reset clears everything
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            rd_q    <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            rdo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdo_q   <= rdo_d;
        end
    end

    // Next-state: start from IDLE (multiply wins a tie), then iterate WIDTH edges
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = is_mult ? S_MUL : S_DIV;
            S_MUL:  if (last) state_d = S_DONE;
            S_DIV:  if (dz_q || last) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: latch operands at start, one add-shift or restore step per edge
    always_comb begin
        cnt_d = cnt_q;
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        neg_d = neg_q;
        dz_d  = dz_q;
        ovf_d = ovf_q;
        rd_d  = rd_q;
        res_d = res_q;
        exc_d = exc_q;
        rdo_d = rdo_q;

        // Multiply step: conditionally add the multiplicand into the high half, then shift right
        msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next = {msum, acc_q[WIDTH-1:1]};
        prod     = neg_q ? -mul_next : mul_next;

        // Divide step: bring the next dividend bit into the remainder and trial-subtract
        trial    = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
        ge       = (trial >= {1'b0, b_q});
        quo_next = {a_q[WIDTH-2:0], ge};
        quo      = neg_q ? -quo_next : quo_next;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    a_d   = abs_a;
                    b_d   = abs_b;
                    acc_d = is_mult ? {{WIDTH{1'b0}}, abs_b} : '0;
                    neg_d = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                    dz_d  = (operand_b == '0);
                    ovf_d = (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_b == '1);
                    rd_d  = rd_in;
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = mul_next;
                if (last) begin
                    res_d = prod[WIDTH-1:0];
                    exc_d = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
                    rdo_d = rd_q;
                end
            end
            S_DIV: begin
                if (dz_q) begin
                    res_d = '0;
                    exc_d = 1'b1;
                    rdo_d = rd_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    acc_d = {{WIDTH{1'b0}}, ge ? (trial[WIDTH-1:0] - b_q) : trial[WIDTH-1:0]};
                    a_d   = quo_next;
                    if (last) begin
                        res_d = quo;
                        exc_d = ovf_q;
                        rdo_d = rd_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs: stall covers the accepting IDLE cycle and all iterating cycles
    always_comb begin
        stall      = reset_n & (((state_q == S_IDLE) & start) |
                                (state_q == S_MUL) | (state_q == S_DIV));
        result_rdy = (state_q == S_DONE);
        result     = res_q;
        exception  = exc_q;
        rd_out     = rdo_q;
    end

endmodule

// File: tb/tb_multdiv_x_unit.sv
// Directed bench for multdiv_x_unit with a scoreboard of expected completions.
module tb_multdiv_x_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        is_mult = 1'b0, is_div = 1'b0;
    logic [31:0] operand_a = '0, operand_b = '0;
    logic [4:0]  rd_in = '0;
    logic        stall, exception, result_rdy;
    logic [31:0] result;
    logic [4:0]  rd_out;

    multdiv_x_unit #(.WIDTH(32), .TAG_W(5)) dut (
        .clock(clock), .reset_n(reset_n), .is_mult(is_mult), .is_div(is_div),
        .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
        .stall(stall), .result(result), .exception(exception),
        .result_rdy(result_rdy), .rd_out(rd_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic [4:0]  rd;
        int          lat;
        int          skip;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive an op at a negedge and push its reference result
    task automatic start_op(input bit m, input bit d, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input bit b2b);
        exp_t   e;
        longint p;
        is_mult = m; is_div = d; operand_a = a; operand_b = b; rd_in = rd;
        e.lat = 32 + int'(b2b);
        if (m) begin
            p     = longint'(signed'(a)) * longint'(signed'(b));
            e.res = p[31:0];
            e.exc = (p != longint'(signed'(p[31:0])));
        end else if (b == 32'd0) begin
            e.res = 32'd0; e.exc = 1'b1; e.lat = 1 + int'(b2b);
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000; e.exc = 1'b1;
        end else begin
            e.res = 32'(signed'(a) / signed'(b)); e.exc = 1'b0;
        end
        e.rd   = rd;
        e.skip = int'(b2b);
        exp_q.push_back(e);
        if (!b2b) begin
            #1 chk1("stall_accept", stall, 1'b1);
        end
    endtask

    // Wait (bounded) for result_rdy, then pop and compare
    task automatic wait_done(input string tag);
        exp_t e;
        int   sc = 0;
        bit   got = 0;
        int   skip;
        skip = exp_q.size() > 0 ? exp_q[0].skip : 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (result_rdy) begin got = 1; break; end
            if (stall) sc++;
            if (i == skip) begin
                operand_a = ~operand_a;
                operand_b = operand_b + 32'd3;
            end
        end
        chk1({tag, "_rdy_seen"}, got, 1'b1);
        if (exp_q.size() == 0) begin
            chk1({tag, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_stall_cycles"}, 32'(sc), 32'(e.lat));
            chk({tag, "_result"}, result, e.res);
            chk1({tag, "_exception"}, exception, e.exc);
            chk({tag, "_rd_out"}, 32'(rd_out), 32'(e.rd));
            chk1({tag, "_stall_done"}, stall, 1'b0);
        end
    endtask

    task automatic idle_check(input string tag);
        is_mult = 1'b0; is_div = 1'b0;
        @(negedge clock);
        chk1({tag, "_rdy_oneshot"}, result_rdy, 1'b0);
        chk1({tag, "_stall_idle"}, stall, 1'b0);
    endtask

    initial begin
        bit any_rdy;
        // Reset state, with a strobe present to confirm stall stays low in reset
        is_mult = 1'b1;
        repeat (2) @(negedge clock);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_rdy", result_rdy, 1'b0);
        chk("rst_result", result, 32'd0);
        chk1("rst_exc", exception, 1'b0);
        chk("rst_rd", 32'(rd_out), 32'd0);
        is_mult = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);

        start_op(1, 0, 32'd3, 32'hFFFF_FFF9, 5'd12, 0); wait_done("mul_3x-7"); idle_check("mul_3x-7");
        start_op(1, 0, 32'h0001_0000, 32'h0001_0000, 5'd3, 0); wait_done("mul_ovf"); idle_check("mul_ovf");
        start_op(1, 0, 32'h7FFF_FFFF, 32'd2, 5'd4, 0); wait_done("mul_max2"); idle_check("mul_max2");
        start_op(0, 1, -32'd100, 32'd7, 5'd9, 0); wait_done("div_-100/7"); idle_check("div_-100/7");
        start_op(0, 1, 32'd100, -32'd7, 5'd10, 0); wait_done("div_100/-7"); idle_check("div_100/-7");
        start_op(0, 1, 32'd6, 32'd3, 5'd11, 0); wait_done("div_6/3"); idle_check("div_6/3");
        start_op(0, 1, 32'd5, 32'd0, 5'd13, 0); wait_done("div_by0"); idle_check("div_by0");
        start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0); wait_done("div_ovf"); idle_check("div_ovf");

        // Abort a multiply with reset at edge 10
        is_mult = 1'b1; operand_a = 32'd123; operand_b = 32'd456; rd_in = 5'd15;
        @(posedge clock);
        repeat (10) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk1("abort_stall", stall, 1'b0);
        chk1("abort_rdy", result_rdy, 1'b0);
        chk("abort_result", result, 32'd0);
        chk1("abort_exc", exception, 1'b0);
        chk("abort_rd", 32'(rd_out), 32'd0);
        is_mult = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        any_rdy = 1'b0;
        repeat (40) begin
            @(negedge clock);
            any_rdy |= result_rdy;
        end
        chk1("abort_no_rdy", any_rdy, 1'b0);
        start_op(0, 1, 32'd9, 32'd2, 5'd7, 0); wait_done("div_9/2"); idle_check("div_9/2");

        // Both strobes: multiply is taken
        start_op(1, 1, 32'd4, 32'd2, 5'd16, 0); wait_done("both"); idle_check("both");

        // Back-to-back multiplies
        start_op(1, 0, -32'd5, 32'd6, 5'd20, 0); wait_done("b2b_1");
        start_op(1, 0, 32'd7, -32'd9, 5'd21, 1); wait_done("b2b_2"); idle_check("b2b_2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
